// File: rtl/bram_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : bram_sweep_ctrl_if -- host, RAM and sweep-status bundle
// Rev    : 1.0 initial release
// ============================================================================
interface bram_sweep_ctrl_if #(
  parameter int WID_MEM = 18,
  parameter int ADDR_W  = 12
);
  logic               start;
  logic [1:0]         mode;
  logic [WID_MEM-1:0] pattern;
  logic               host_we;
  logic [ADDR_W-1:0]  host_waddr;
  logic [WID_MEM-1:0] host_wdata;
  logic               host_re;
  logic [ADDR_W-1:0]  host_raddr;
  logic               host_ready;
  logic [WID_MEM-1:0] host_rdata;
  logic               host_rvalid;
  logic [ADDR_W-1:0]  mem_raddr;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [WID_MEM-1:0] mem_din;
  logic               mem_we;
  logic [WID_MEM-1:0] mem_dout;
  logic               busy;
  logic               done;
  logic [ADDR_W:0]    err_count;
  logic [ADDR_W-1:0]  first_err_addr;

  modport slave (
    input  start, mode, pattern,
    input  host_we, host_waddr, host_wdata, host_re, host_raddr,
    output host_ready, host_rdata, host_rvalid,
    output mem_raddr, mem_waddr, mem_din, mem_we,
    input  mem_dout,
    output busy, done, err_count, first_err_addr
  );

  modport master (
    output start, mode, pattern,
    output host_we, host_waddr, host_wdata, host_re, host_raddr,
    input  host_ready, host_rdata, host_rvalid,
    input  mem_raddr, mem_waddr, mem_din, mem_we,
    output mem_dout,
    input  busy, done, err_count, first_err_addr
  );
endinterface
`default_nettype wire

// File: rtl/bram_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : bram_sweep_ctrl -- host pass-through plus fill/check sweeps of a BRAM
// Rev    : 1.0 initial release
// ============================================================================
module bram_sweep_ctrl #(
  parameter int WID_MEM   = 18,
  parameter int ADDR_W    = 12,
  parameter int DEPTH_MEM = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  bram_sweep_ctrl_if.slave bus
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_fill  = 3'd1;
  localparam logic [2:0] c_st_check = 3'd2;
  localparam logic [2:0] c_st_drain = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH_MEM - 1);
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_err_one   = (ADDR_W+1)'(1);

  logic [2:0]         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [WID_MEM-1:0] r_pattern;
  logic               r_addr_mix;
  logic               r_cmp_valid;
  logic [ADDR_W-1:0]  r_cmp_addr;
  logic [ADDR_W:0]    r_err_count;
  logic [ADDR_W-1:0]  r_first_err_addr;
  logic               r_host_rvalid;

  logic               w_idle;
  logic               w_host_ready;
  logic               w_accept;
  logic               w_last;
  logic [WID_MEM-1:0] w_fill_word;
  logic [WID_MEM-1:0] w_check_word;
  logic               w_mismatch;
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_waddr;
  logic [ADDR_W-1:0]  w_mem_raddr;
  logic [WID_MEM-1:0] w_mem_din;

  assign w_idle       = (r_state == c_st_idle);
  assign w_host_ready = w_idle & ~bus.start;
  // Mode 11 is reserved: a start carrying it is simply not accepted.
  assign w_accept     = w_idle & bus.start & (bus.mode != 2'b11);
  assign w_last       = (r_addr == c_last_addr);

  assign w_fill_word  = r_pattern ^ (r_addr_mix ? WID_MEM'(r_addr) : '0);
  assign w_check_word = r_pattern ^ WID_MEM'(r_cmp_addr);
  assign w_mismatch   = r_cmp_valid & (bus.mem_dout != w_check_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= c_st_idle;
      r_addr           <= '0;
      r_pattern        <= '0;
      r_addr_mix       <= 1'b0;
      r_cmp_valid      <= 1'b0;
      r_cmp_addr       <= '0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_host_rvalid    <= 1'b0;
    end else begin
      r_host_rvalid <= bus.host_re & w_host_ready;
      // Read data returns one cycle after issue, so the address is delayed to match.
      r_cmp_valid   <= (r_state == c_st_check);
      r_cmp_addr    <= r_addr;

      if (w_accept) begin
        r_err_count      <= '0;
        r_first_err_addr <= '0;
      end else if (w_mismatch) begin
        r_err_count <= r_err_count + c_err_one;
        if (r_err_count == '0) begin
          r_first_err_addr <= r_cmp_addr;
        end
      end

      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_state    <= (bus.mode == 2'b10) ? c_st_check : c_st_fill;
            r_pattern  <= bus.pattern;
            r_addr_mix <= (bus.mode != 2'b00);
            r_addr     <= '0;
          end
        end
        c_st_fill: begin
          if (w_last) begin
            r_state <= c_st_done;
          end else begin
            r_addr <= r_addr + c_addr_one;
          end
        end
        c_st_check: begin
          if (w_last) begin
            r_state <= c_st_drain;
          end else begin
            r_addr <= r_addr + c_addr_one;
          end
        end
        c_st_drain: r_state <= c_st_done;
        c_st_done:  r_state <= c_st_idle;
        default:    r_state <= c_st_idle;
      endcase
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_addr;
    w_mem_raddr = r_addr;
    w_mem_din   = w_fill_word;
    if (w_idle) begin
      w_mem_we    = bus.host_we & w_host_ready;
      w_mem_waddr = bus.host_waddr;
      w_mem_raddr = bus.host_raddr;
      w_mem_din   = bus.host_wdata;
    end else if (r_state == c_st_fill) begin
      w_mem_we = 1'b1;
    end
  end

  assign bus.mem_we         = w_mem_we;
  assign bus.mem_waddr      = w_mem_waddr;
  assign bus.mem_raddr      = w_mem_raddr;
  assign bus.mem_din        = w_mem_din;
  assign bus.host_ready     = w_host_ready;
  assign bus.host_rdata     = bus.mem_dout;
  assign bus.host_rvalid    = r_host_rvalid;
  assign bus.busy           = (r_state == c_st_fill) | (r_state == c_st_check) |
                              (r_state == c_st_drain);
  assign bus.done           = (r_state == c_st_done);
  assign bus.err_count      = r_err_count;
  assign bus.first_err_addr = r_first_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_bram_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_bram_sweep_ctrl -- randomized bench with a RAM model and reference memory
// Rev    : 1.0 initial release
// ============================================================================
module tb_bram_sweep_ctrl;

  localparam int DEPTH = 4096;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [17:0] ram     [DEPTH];
  logic [17:0] ref_mem [DEPTH];

  bram_sweep_ctrl_if #(.WID_MEM(18), .ADDR_W(12)) bus ();

  bram_sweep_ctrl #(.WID_MEM(18), .ADDR_W(12), .DEPTH_MEM(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first simple-dual-port RAM with a registered read port.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_waddr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_raddr];
  end

  task automatic clear_inputs();
    bus.start = 1'b0; bus.mode = 2'b00; bus.pattern = '0;
    bus.host_we = 1'b0; bus.host_waddr = '0; bus.host_wdata = '0;
    bus.host_re = 1'b0; bus.host_raddr = '0;
  endtask

  // One IDLE-cycle host access; a read returns the contents before any same-cycle write.
  task automatic host_op(input bit we, input logic [11:0] wa, input logic [17:0] wd,
                         input bit re, input logic [11:0] ra);
    logic [17:0] exp_rd;
    exp_rd = ref_mem[ra];
    bus.host_we = we; bus.host_waddr = wa; bus.host_wdata = wd;
    bus.host_re = re; bus.host_raddr = ra;
    #1;
    checks++;
    if (bus.host_ready !== 1'b1 || bus.mem_we !== we) begin
      errors++;
      $display("FAIL host_accept ready=%b mem_we=%b exp ready=1 mem_we=%b",
               bus.host_ready, bus.mem_we, we);
    end
    @(posedge clk); #1;
    bus.host_we = 1'b0; bus.host_re = 1'b0;
    if (we) ref_mem[wa] = wd;
    checks++;
    if (re) begin
      if (bus.host_rvalid !== 1'b1 || bus.host_rdata !== exp_rd) begin
        errors++;
        $display("FAIL host_read addr=%h rvalid=%b data=%h exp rvalid=1 data=%h",
                 ra, bus.host_rvalid, bus.host_rdata, exp_rd);
      end
    end else if (bus.host_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL host_rvalid_idle got %b exp 0", bus.host_rvalid);
    end
  endtask

  // Issues a start and follows the whole sweep cycle by cycle against the timing rules.
  task automatic run_sweep(input logic [1:0] m, input logic [17:0] p, input bit noise,
                           input int mid_start, input bit host_at_start,
                           output int done_at, output int n_we);
    int          seq_bad;
    int          exp_done;
    bit          fill;
    logic [17:0] exp_din;
    fill     = (m != 2'b10);
    exp_done = fill ? DEPTH : DEPTH + 1;
    seq_bad  = 0;
    done_at  = -1;
    n_we     = 0;
    bus.start = 1'b1; bus.mode = m; bus.pattern = p;
    bus.host_we = host_at_start; bus.host_re = host_at_start;
    bus.host_waddr = 12'($urandom); bus.host_wdata = 18'($urandom);
    bus.host_raddr = 12'($urandom);
    #1;
    checks++;
    if (bus.host_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL start_priority ready=%b mem_we=%b exp 0 0", bus.host_ready, bus.mem_we);
    end
    @(posedge clk); #1;
    for (int c = 0; c < DEPTH + 8; c++) begin
      bus.start   = (c == mid_start);
      bus.mode    = (c == mid_start) ? 2'b10 : m;
      bus.pattern = (c == mid_start) ? ~p : p;
      if (noise && c < DEPTH - 1) begin
        bus.host_we = 1'($urandom); bus.host_waddr = 12'($urandom);
        bus.host_wdata = 18'($urandom); bus.host_re = 1'($urandom);
        bus.host_raddr = 12'($urandom);
      end else begin
        bus.host_we = 1'b0; bus.host_re = 1'b0;
      end
      #1;
      if (bus.mem_we === 1'b1) n_we++;
      if (bus.done === 1'b1 && done_at < 0) done_at = c;
      if (bus.busy !== (c < exp_done) || bus.done !== (c == exp_done)) seq_bad++;
      if (c < exp_done && bus.host_ready !== 1'b0) seq_bad++;
      if (c <= exp_done && bus.host_rvalid !== 1'b0) seq_bad++;
      if (fill && c < DEPTH) begin
        exp_din = p ^ ((m == 2'b01) ? 18'(c) : 18'd0);
        if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 12'(c) || bus.mem_din !== exp_din)
          seq_bad++;
      end
      if (!fill && c <= DEPTH && bus.mem_we !== 1'b0) seq_bad++;
      if (!fill && c < DEPTH && bus.mem_raddr !== 12'(c)) seq_bad++;
      if (c == exp_done + 1) begin
        if (bus.host_ready !== 1'b1) seq_bad++;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (seq_bad != 0) begin
      errors++;
      $display("FAIL sweep_sequence mode=%0d bad_cycles=%0d exp 0", m, seq_bad);
    end
    if (fill) begin
      for (int a = 0; a < DEPTH; a++) ref_mem[a] = p ^ ((m == 2'b01) ? 18'(a) : 18'd0);
    end
  endtask

  task automatic check_result(input logic [17:0] p, input string name);
    int          exp_err;
    logic [11:0] exp_first;
    exp_err   = 0;
    exp_first = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (ref_mem[a] !== (p ^ 18'(a))) begin
        if (exp_err == 0) exp_first = 12'(a);
        exp_err++;
      end
    end
    checks++;
    if (bus.err_count !== 13'(exp_err) || bus.first_err_addr !== exp_first) begin
      errors++;
      $display("FAIL %s err_count=%0d first=%h exp err_count=%0d first=%h",
               name, bus.err_count, bus.first_err_addr, exp_err, exp_first);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    bus.host_waddr = 12'h005; bus.host_raddr = 12'h009;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.host_rvalid !== 1'b0 ||
        bus.err_count !== 13'd0 || bus.first_err_addr !== 12'd0 ||
        bus.host_ready !== 1'b1 || bus.mem_we !== 1'b0 ||
        bus.mem_waddr !== 12'h005 || bus.mem_raddr !== 12'h009) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b rv=%b err=%0d ready=%b we=%b wa=%h ra=%h",
               bus.busy, bus.done, bus.host_rvalid, bus.err_count, bus.host_ready,
               bus.mem_we, bus.mem_waddr, bus.mem_raddr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_const();
    int done_at, n_we;
    run_sweep(2'b00, 18'h2AAAA, 1'b0, -1, 1'b0, done_at, n_we);
    expect_int("fill_const_done_cycle", done_at, DEPTH);
    expect_int("fill_const_we_cycles", n_we, DEPTH);
    host_op(1'b0, '0, '0, 1'b1, 12'h000);
    host_op(1'b0, '0, '0, 1'b1, 12'h7FF);
    host_op(1'b0, '0, '0, 1'b1, 12'hFFF);
  endtask

  task automatic test_host_random();
    for (int i = 0; i < 40; i++) begin
      host_op(1'($urandom), 12'($urandom_range(0, 7)), 18'($urandom),
              1'($urandom), 12'($urandom_range(0, 7)));
    end
    host_op(1'b1, 12'h3, 18'h15555, 1'b1, 12'h3);
    host_op(1'b0, '0, '0, 1'b1, 12'h3);
  endtask

  task automatic test_fill_check_clean();
    int done_at, n_we;
    run_sweep(2'b01, 18'h00000, 1'b0, -1, 1'b0, done_at, n_we);
    expect_int("fill_addr_done_cycle", done_at, DEPTH);
    run_sweep(2'b10, 18'h00000, 1'b0, -1, 1'b0, done_at, n_we);
    expect_int("check_done_cycle", done_at, DEPTH + 1);
    expect_int("check_we_cycles", n_we, 0);
    check_result(18'h00000, "check_clean");
  endtask

  task automatic test_check_errors();
    int done_at, n_we;
    host_op(1'b1, 12'h123, 18'h00000, 1'b0, '0);
    host_op(1'b1, 12'h800, 18'h3FFFF, 1'b0, '0);
    run_sweep(2'b10, 18'h00000, 1'b0, -1, 1'b0, done_at, n_we);
    expect_int("check_err_count_two", int'(bus.err_count), 2);
    check_result(18'h00000, "check_two_errors");
  endtask

  task automatic test_random_check();
    int          done_at, n_we;
    logic [17:0] p;
    for (int r = 0; r < 2; r++) begin
      p = 18'($urandom);
      run_sweep(2'b01, p, 1'b0, -1, 1'b0, done_at, n_we);
      for (int k = 0; k < r * 4; k++)
        host_op(1'b1, 12'($urandom), 18'($urandom), 1'b0, '0);
      run_sweep(2'b10, p, 1'b1, -1, 1'b0, done_at, n_we);
      check_result(p, "check_random");
    end
  endtask

  task automatic test_ignored_starts();
    int done_at, n_we;
    int dones;
    logic [17:0] p;
    p = 18'($urandom);
    run_sweep(2'b00, p, 1'b1, 100, 1'b0, done_at, n_we);
    expect_int("midstart_done_cycle", done_at, DEPTH);
    host_op(1'b0, '0, '0, 1'b1, 12'($urandom));
    bus.start = 1'b1; bus.mode = 2'b11; bus.host_we = 1'b1;
    bus.host_waddr = 12'h010; bus.host_wdata = 18'h1;
    #1;
    checks++;
    if (bus.host_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL mode11_ready ready=%b mem_we=%b exp 0 0", bus.host_ready, bus.mem_we);
    end
    @(posedge clk); #1;
    clear_inputs();
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) dones++;
      @(posedge clk); #1;
    end
    expect_int("mode11_no_activity", dones, 0);
  endtask

  task automatic test_reset_mid_fill();
    bus.start = 1'b1; bus.mode = 2'b01; bus.pattern = 18'($urandom);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill_busy got %b exp 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err_count !== 13'd0 ||
        bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort busy=%b done=%b err=%0d we=%b exp 0 0 0 0",
               bus.busy, bus.done, bus.err_count, bus.mem_we);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.host_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready=%b busy=%b exp 1 0", bus.host_ready, bus.busy);
    end
  endtask

  task automatic test_start_vs_host();
    int          done_at, n_we;
    logic [17:0] p;
    p = 18'($urandom);
    run_sweep(2'b00, p, 1'b0, -1, 1'b1, done_at, n_we);
    expect_int("start_host_we_cycles", n_we, DEPTH);
    host_op(1'b0, '0, '0, 1'b1, 12'($urandom));
  endtask

  task automatic test_back_to_back();
    int          done_at, n_we;
    logic [17:0] p;
    p = 18'($urandom);
    run_sweep(2'b01, p, 1'b0, -1, 1'b0, done_at, n_we);
    run_sweep(2'b10, p, 1'b1, -1, 1'b0, done_at, n_we);
    expect_int("b2b_check_done_cycle", done_at, DEPTH + 1);
    check_result(p, "b2b_check");
    run_sweep(2'b10, ~p, 1'b0, -1, 1'b0, done_at, n_we);
    check_result(~p, "b2b_check_all_wrong");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_const();
    test_host_random();
    test_fill_check_clean();
    test_check_errors();
    test_random_check();
    test_ignored_starts();
    test_reset_mid_fill();
    test_start_vs_host();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
